// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory port between the IFU (read-only) and the LSU.
// Each access is latched in IDLE, runs MEM_LAT wait cycles (men on the last), then pulses one response.
module pmem_arbiter #(
    parameter int MEM_LAT  = 1,
    parameter int LSU_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_addr,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_data,
    output logic        men,
    output logic        mwen,
    output logic [63:0] raddr,
    output logic [63:0] waddr,
    output logic [63:0] wdata,
    output logic [7:0]  wmask,
    input  logic [63:0] rdata
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner;       // 1 = LSU
    logic          last_grant;  // 1 = LSU
    logic          acc_wen;
    logic [63:0]   addr;
    logic          grant_lsu;

    // On a tie the LSU wins under fixed priority, or when the IFU had the previous grant.
    assign grant_lsu = lsu_req_valid &&
                       (!ifu_req_valid || (LSU_PRIO != 0) || !last_grant);

    always_comb begin
        ifu_req_ready  = (state == IDLE) && ifu_req_valid && !grant_lsu;
        lsu_req_ready  = (state == IDLE) && grant_lsu;
        men            = (state == WAIT) && (cnt == '0);
        mwen           = men && acc_wen;
        ifu_resp_valid = (state == RESP) && !owner;
        lsu_resp_valid = (state == RESP) && owner;
    end

    assign raddr = addr;
    assign waddr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            acc_wen       <= 1'b0;
            addr          <= '0;
            wdata         <= '0;
            wmask         <= '0;
            ifu_resp_data <= '0;
            lsu_resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_req_ready || lsu_req_ready) begin
                        owner      <= lsu_req_ready;
                        last_grant <= lsu_req_ready;
                        addr       <= lsu_req_ready ? lsu_req_addr : ifu_req_addr;
                        acc_wen    <= lsu_req_ready && lsu_req_wen;
                        wdata      <= lsu_req_ready ? lsu_req_wdata : 64'd0;
                        wmask      <= lsu_req_ready ? lsu_req_wmask : 8'd0;
                        cnt        <= CW'(MEM_LAT - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner) lsu_resp_data <= acc_wen ? 64'd0 : rdata;
                        else       ifu_resp_data <= rdata;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: instance 0 runs MEM_LAT=1 round-robin, instance 1 MEM_LAT=3 LSU priority.
// Directed scenarios plus randomized traffic against a timing-rule reference model.
module tb_pmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ifu_req_valid = 1'b0;
    logic [63:0] ifu_req_addr  = '0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_wen   = 1'b0;
    logic [63:0] lsu_req_addr  = '0;
    logic [63:0] lsu_req_wdata = '0;
    logic [7:0]  lsu_req_wmask = '0;

    wire [1:0]  x_ifu_rdy, x_lsu_rdy, x_ifu_rv, x_lsu_rv, x_men, x_mwen;
    wire [63:0] x_ifu_rd [2];
    wire [63:0] x_lsu_rd [2];
    wire [63:0] x_raddr  [2];
    wire [63:0] x_waddr  [2];
    wire [63:0] x_wdata  [2];
    wire [63:0] x_rdata  [2];
    wire [7:0]  x_wmask  [2];

    int sel = 0;
    int cyc = 0;
    int compares = 0;
    int fails = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as a pure function of address; 0x80000000 holds 0x13.
    function automatic logic [63:0] memf(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h13 : {a[31:0] ^ 32'hC0DE_0001, ~a[63:32]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pmem_arbiter #(.MEM_LAT(g == 1 ? 3 : 1), .LSU_PRIO(g)) u_dut (
            .clk(clk), .rst(rst),
            .ifu_req_valid(ifu_req_valid), .ifu_req_ready(x_ifu_rdy[g]),
            .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(x_ifu_rv[g]),
            .ifu_resp_data(x_ifu_rd[g]),
            .lsu_req_valid(lsu_req_valid), .lsu_req_ready(x_lsu_rdy[g]),
            .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
            .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
            .lsu_resp_valid(x_lsu_rv[g]), .lsu_resp_data(x_lsu_rd[g]),
            .men(x_men[g]), .mwen(x_mwen[g]), .raddr(x_raddr[g]), .waddr(x_waddr[g]),
            .wdata(x_wdata[g]), .wmask(x_wmask[g]), .rdata(x_rdata[g])
        );
        assign x_rdata[g] = memf(x_raddr[g]);
    end

    // Reference model: an accepted request at cycle t touches memory at t+L,
    // responds at t+L+1 and the port is free again at t+L+2.
    bit          busy, last, m_who, m_wen;
    int          t_acc;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wmask;
    logic [63:0] hold [2];
    bit          e_ifu_rdy, e_lsu_rdy, e_ifu_rv, e_lsu_rv, e_men, e_mwen, e_who, e_acc;
    logic [63:0] e_ifu_d, e_lsu_d, e_addr, e_wdata;
    logic [7:0]  e_wmask;

    task automatic model_reset();
        busy = 0; last = 1; t_acc = 0; m_who = 0; m_wen = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0; hold[0] = '0; hold[1] = '0;
    endtask

    task automatic model_cycle();
        int L;
        bit P;
        L = (sel == 1) ? 3 : 1;
        P = (sel == 1);
        if (busy && cyc > t_acc + L + 1) busy = 0;
        e_men    = busy && cyc == t_acc + L;
        e_mwen   = e_men && m_wen;
        e_ifu_rv = busy && cyc == t_acc + L + 1 && !m_who;
        e_lsu_rv = busy && cyc == t_acc + L + 1 && m_who;
        if (e_ifu_rv || e_lsu_rv) hold[m_who] = m_wen ? 64'd0 : memf(m_addr);
        e_ifu_d = hold[0]; e_lsu_d = hold[1];
        e_addr = m_addr; e_wdata = m_wdata; e_wmask = m_wmask;
        e_who = lsu_req_valid && (!ifu_req_valid || P || !last);
        e_acc = !busy && (ifu_req_valid || lsu_req_valid);
        e_ifu_rdy = e_acc && !e_who;
        e_lsu_rdy = e_acc && e_who;
        if (e_acc) begin
            busy = 1; t_acc = cyc; m_who = e_who; last = e_who;
            m_addr  = e_who ? lsu_req_addr : ifu_req_addr;
            m_wen   = e_who && lsu_req_wen;
            m_wdata = e_who ? lsu_req_wdata : 64'd0;
            m_wmask = e_who ? lsu_req_wmask : 8'd0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        model_reset();
    endtask

    // Recorded by run_one, relative to the accept cycle (bit k = k cycles later).
    logic [7:0]  men_pat, mwen_pat, ifu_rv_pat, lsu_rv_pat;
    logic [63:0] r_raddr, r_waddr, r_wdata, r_data;
    logic [7:0]  r_wmask;

    task automatic run_one(input bit who, input logic [63:0] a, input bit wen,
                           input logic [63:0] wd, input logic [7:0] wm);
        bit acc;
        ifu_req_valid = !who; ifu_req_addr = a;
        lsu_req_valid = who;  lsu_req_addr = a; lsu_req_wen = wen;
        lsu_req_wdata = wd;   lsu_req_wmask = wm;
        acc = 0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = who ? x_lsu_rdy[sel] : x_ifu_rdy[sel];
            next_cycle();
        end
        compares++;
        if (!acc) begin
            fails++;
            $display("FAIL accept_timeout: accepted=%0b required=1", acc);
        end
        // Scramble inputs so only the latched copy can produce correct results.
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_req_addr = {$urandom, $urandom}; lsu_req_addr = {$urandom, $urandom};
        lsu_req_wdata = {$urandom, $urandom}; lsu_req_wmask = 8'($urandom);
        lsu_req_wen = 1'($urandom);
        men_pat = '0; mwen_pat = '0; ifu_rv_pat = '0; lsu_rv_pat = '0;
        r_raddr = '0; r_waddr = '0; r_wdata = '0; r_wmask = '0; r_data = '1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            men_pat[k]    = x_men[sel];
            mwen_pat[k]   = x_mwen[sel];
            ifu_rv_pat[k] = x_ifu_rv[sel];
            lsu_rv_pat[k] = x_lsu_rv[sel];
            if (x_men[sel]) begin
                r_raddr = x_raddr[sel]; r_waddr = x_waddr[sel];
                r_wdata = x_wdata[sel]; r_wmask = x_wmask[sel];
            end
            if (x_ifu_rv[sel] || x_lsu_rv[sel])
                r_data = who ? x_lsu_rd[sel] : x_ifu_rd[sel];
            next_cycle();
        end
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        @(negedge clk);
        compares++;
        if ({x_ifu_rdy, x_lsu_rdy, x_ifu_rv, x_lsu_rv, x_men, x_mwen} !== 12'd0) begin
            fails++;
            $display("FAIL reset_ctl: got %h want 000",
                     {x_ifu_rdy, x_lsu_rdy, x_ifu_rv, x_lsu_rv, x_men, x_mwen});
        end
        for (int g = 0; g < 2; g++) begin
            compares++;
            if ({x_ifu_rd[g], x_lsu_rd[g], x_raddr[g], x_waddr[g], x_wdata[g], x_wmask[g]} !== '0) begin
                fails++;
                $display("FAIL reset_data[%0d]: got %h %h %h %h %h %h want all 0", g,
                         x_ifu_rd[g], x_lsu_rd[g], x_raddr[g], x_waddr[g], x_wdata[g], x_wmask[g]);
            end
        end
        next_cycle();
    endtask

    task automatic test_ifu_read();
        sel = 0;
        do_reset();
        run_one(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'd0);
        compares++;
        if ({men_pat, mwen_pat} !== {8'b0000_0010, 8'b0}) begin
            fails++;
            $display("FAIL ifu_men_timing: men=%b mwen=%b want men=00000010 mwen=0", men_pat, mwen_pat);
        end
        compares++;
        if ({ifu_rv_pat, lsu_rv_pat} !== {8'b0000_0100, 8'b0}) begin
            fails++;
            $display("FAIL ifu_resp_timing: ifu=%b lsu=%b want ifu=00000100 lsu=0", ifu_rv_pat, lsu_rv_pat);
        end
        compares++;
        if ({r_raddr, r_data} !== {64'h8000_0000, 64'h13}) begin
            fails++;
            $display("FAIL ifu_read_data: addr=%h data=%h want 80000000/13", r_raddr, r_data);
        end
    endtask

    task automatic test_lsu_write();
        sel = 0;
        do_reset();
        run_one(1'b1, 64'h8000_1000, 1'b1, 64'hDEAD, 8'h0F);
        compares++;
        if ({men_pat, mwen_pat} !== {8'b0000_0010, 8'b0000_0010}) begin
            fails++;
            $display("FAIL lsu_write_strobe: men=%b mwen=%b want 00000010 both", men_pat, mwen_pat);
        end
        compares++;
        if ({r_waddr, r_raddr, r_wdata, r_wmask} !== {64'h8000_1000, 64'h8000_1000, 64'hDEAD, 8'h0F}) begin
            fails++;
            $display("FAIL lsu_write_fields: waddr=%h raddr=%h wdata=%h wmask=%h want 80001000/80001000/dead/0f",
                     r_waddr, r_raddr, r_wdata, r_wmask);
        end
        compares++;
        if ({lsu_rv_pat, ifu_rv_pat, r_data} !== {8'b0000_0100, 8'b0, 64'd0}) begin
            fails++;
            $display("FAIL lsu_write_ack: lsu=%b ifu=%b data=%h want 00000100/0/0", lsu_rv_pat, ifu_rv_pat, r_data);
        end
    endtask

    task automatic test_alternate();
        int n, prev_cyc;
        bit prev_who, who;
        sel = 0;
        do_reset();
        n = 0; prev_cyc = 0; prev_who = 1;
        for (int i = 0; i < 40; i++) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            ifu_req_addr = {$urandom, $urandom}; lsu_req_addr = {$urandom, $urandom};
            lsu_req_wen = 1'($urandom);
            @(negedge clk);
            if (x_ifu_rdy[0] || x_lsu_rdy[0]) begin
                who = x_lsu_rdy[0];
                compares++;
                if ((x_ifu_rdy[0] && x_lsu_rdy[0]) || who !== !prev_who) begin
                    fails++;
                    $display("FAIL rr_grant[%0d]: ifu_rdy=%0b lsu_rdy=%0b want lsu=%0b", n,
                             x_ifu_rdy[0], x_lsu_rdy[0], !prev_who);
                end
                if (n > 0) begin
                    compares++;
                    if (cyc - prev_cyc != 3) begin
                        fails++;
                        $display("FAIL rr_spacing[%0d]: got %0d want 3", n, cyc - prev_cyc);
                    end
                end
                prev_who = who; prev_cyc = cyc; n++;
            end
            next_cycle();
        end
        compares++;
        if (n < 13) begin
            fails++;
            $display("FAIL rr_grant_count: got %0d want >=13", n);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_lsu_prio();
        int n, prev_cyc;
        bit ifu_seen;
        sel = 1;
        do_reset();
        n = 0; prev_cyc = 0; ifu_seen = 0;
        for (int i = 0; i < 40; i++) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_req_wen = 1'b0;
            ifu_req_addr = {$urandom, $urandom}; lsu_req_addr = {$urandom, $urandom};
            @(negedge clk);
            if (x_ifu_rdy[1]) ifu_seen = 1;
            if (x_lsu_rdy[1]) begin
                if (n > 0) begin
                    compares++;
                    if (cyc - prev_cyc != 5) begin
                        fails++;
                        $display("FAIL prio_spacing[%0d]: got %0d want 5", n, cyc - prev_cyc);
                    end
                end
                prev_cyc = cyc; n++;
            end
            next_cycle();
        end
        compares++;
        if (ifu_seen || n < 8) begin
            fails++;
            $display("FAIL prio_grants: ifu_ready_seen=%0b lsu_grants=%0d want 0 / >=8", ifu_seen, n);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_lat3();
        logic [63:0] a;
        sel = 1;
        do_reset();
        a = 64'h8000_2468;
        run_one(1'b1, a, 1'b0, 64'd0, 8'd0);
        compares++;
        if ({men_pat, mwen_pat, lsu_rv_pat} !== {8'b0000_1000, 8'b0, 8'b0001_0000}) begin
            fails++;
            $display("FAIL lat3_timing: men=%b mwen=%b resp=%b want 00001000/0/00010000",
                     men_pat, mwen_pat, lsu_rv_pat);
        end
        compares++;
        if ({r_raddr, r_data} !== {a, memf(a)}) begin
            fails++;
            $display("FAIL lat3_data: addr=%h data=%h want %h/%h", r_raddr, r_data, a, memf(a));
        end
    endtask

    task automatic test_rst_mid();
        bit acc;
        int men_n, rv_n;
        logic [63:0] b;
        sel = 1;
        do_reset();
        ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0040;
        acc = 0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = x_ifu_rdy[1];
            next_cycle();
        end
        ifu_req_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        model_reset();
        men_n = 0; rv_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            men_n += int'(x_men[1]);
            rv_n  += int'(x_ifu_rv[1]) + int'(x_lsu_rv[1]);
            next_cycle();
        end
        compares++;
        if (!acc || men_n != 0 || rv_n != 0 || x_ifu_rd[1] !== 64'd0) begin
            fails++;
            $display("FAIL rst_mid_drop: accepted=%0b men=%0d resp=%0d ifu_data=%h want 1/0/0/0",
                     acc, men_n, rv_n, x_ifu_rd[1]);
        end
        b = 64'h8000_0ABC;
        run_one(1'b1, b, 1'b0, 64'd0, 8'd0);
        compares++;
        if ({men_pat, lsu_rv_pat, r_data} !== {8'b0000_1000, 8'b0001_0000, memf(b)}) begin
            fails++;
            $display("FAIL rst_mid_fresh: men=%b resp=%b data=%h want 00001000/00010000/%h",
                     men_pat, lsu_rv_pat, r_data, memf(b));
        end
    endtask

    task automatic test_random(input int s);
        sel = s;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            ifu_req_valid = ($urandom_range(2) != 0);
            lsu_req_valid = ($urandom_range(2) != 0);
            ifu_req_addr  = {$urandom, $urandom};
            lsu_req_addr  = {$urandom, $urandom};
            lsu_req_wdata = {$urandom, $urandom};
            lsu_req_wmask = 8'($urandom);
            lsu_req_wen   = 1'($urandom);
            @(negedge clk);
            model_cycle();
            compares++;
            if ({x_ifu_rdy[sel], x_lsu_rdy[sel], x_ifu_rv[sel], x_lsu_rv[sel], x_men[sel], x_mwen[sel]} !==
                {e_ifu_rdy, e_lsu_rdy, e_ifu_rv, e_lsu_rv, e_men, e_mwen}) begin
                fails++;
                $display("FAIL rand%0d_ctl @%0d: got %b want %b (rdy_i rdy_l rv_i rv_l men mwen)", s, cyc,
                         {x_ifu_rdy[sel], x_lsu_rdy[sel], x_ifu_rv[sel], x_lsu_rv[sel], x_men[sel], x_mwen[sel]},
                         {e_ifu_rdy, e_lsu_rdy, e_ifu_rv, e_lsu_rv, e_men, e_mwen});
            end
            compares++;
            if ({x_ifu_rd[sel], x_lsu_rd[sel]} !== {e_ifu_d, e_lsu_d}) begin
                fails++;
                $display("FAIL rand%0d_resp_data @%0d: got %h/%h want %h/%h", s, cyc,
                         x_ifu_rd[sel], x_lsu_rd[sel], e_ifu_d, e_lsu_d);
            end
            if (e_men) begin
                compares++;
                if ({x_raddr[sel], x_waddr[sel]} !== {e_addr, e_addr} ||
                    (e_mwen && {x_wdata[sel], x_wmask[sel]} !== {e_wdata, e_wmask})) begin
                    fails++;
                    $display("FAIL rand%0d_mem @%0d: got %h/%h/%h/%h want %h/%h/%h/%h", s, cyc,
                             x_raddr[sel], x_waddr[sel], x_wdata[sel], x_wmask[sel],
                             e_addr, e_addr, e_wdata, e_wmask);
                end
            end
            next_cycle();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        next_cycle();
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_alternate();
        test_lsu_prio();
        test_lat3();
        test_rst_mid();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
